// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and constants for the skew feeder.
// Holds FSM encodings, a clog2 helper and the default array geometry.
package systolic_skew_feeder_pkg;

    localparam int DEF_LANES  = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_delay_lane.sv
// Per-lane delay line carrying {valid, data}.
// DEPTH register stages, every stage cleared by the async reset.
module skew_delay_lane #(
    parameter int DEPTH = 1,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic [DEPTH-1:0] r_valid;
    logic [W-1:0]     r_data [DEPTH];

    // shift valid and data one stage per clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Input stage of the systolic array: vector FIFO plus diagonal skew.
// Lane k of each popped vector appears k cycles after lane 0.
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic                    in_last,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [LANES-1:0]        out_lane_valid,
    output logic                    tile_done,
    output logic                    busy
);

    localparam int VW = LANES * DATA_W;
    localparam int AW = clog2(FIFO_DEPTH);
    localparam int CW = clog2(LANES);
    localparam logic [CW-1:0] CNT_LAST = CW'(LANES - 2);

    logic [VW:0]   r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [VW:0]   w_head;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_stg_valid;
    logic          r_stg_last;
    logic [VW-1:0] r_stg_data;
    logic [DATA_W:0] w_end_q;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push   = in_valid && !w_full;
    assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
    assign in_ready = !w_full;
    assign busy     = (r_state != ST_IDLE) || !w_empty;

    // FIFO storage of {last, data} and its wrap-safe pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= {in_last, in_data};
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // FSM state and drain counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // pop decision and next state; a last entry starts the drain
    always_comb begin
        w_pop       = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE, ST_FEED: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head[VW]) begin
                        w_state_nxt = ST_DRAIN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_FEED;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // pop stage; lane 0 is driven straight from it, bubbles carry zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_valid <= 1'b0;
            r_stg_last  <= 1'b0;
            r_stg_data  <= '0;
        end else begin
            r_stg_valid <= w_pop;
            r_stg_last  <= w_pop && w_head[VW];
            r_stg_data  <= w_pop ? w_head[VW-1:0] : '0;
        end
    end

    assign out_data[DATA_W-1:0] = r_stg_data[DATA_W-1:0];
    assign out_lane_valid[0]    = r_stg_valid;

    generate
        for (genvar k = 1; k < LANES; k++) begin : g_lane
            if (k < LANES - 1) begin : g_mid
                skew_delay_lane #(
                    .DEPTH (k),
                    .W     (DATA_W)
                ) u_dly (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .i_valid (r_stg_valid),
                    .i_data  (r_stg_data[k*DATA_W +: DATA_W]),
                    .o_valid (out_lane_valid[k]),
                    .o_data  (out_data[k*DATA_W +: DATA_W])
                );
            end else begin : g_end
                // last lane also carries the tile's last flag
                skew_delay_lane #(
                    .DEPTH (k),
                    .W     (DATA_W + 1)
                ) u_dly (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .i_valid (r_stg_valid),
                    .i_data  ({r_stg_last,
                               r_stg_data[k*DATA_W +: DATA_W]}),
                    .o_valid (out_lane_valid[k]),
                    .o_data  (w_end_q)
                );
                assign out_data[k*DATA_W +: DATA_W] = w_end_q[DATA_W-1:0];
            end
        end
    endgenerate

    assign tile_done = w_end_q[DATA_W];

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder (LANES=4, DATA_W=8, FIFO_DEPTH=4).
// Queue-level model plus directed checks with hand-computed values.
module tb_systolic_skew_feeder;

    localparam int L  = 4;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int NL = 4096;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [L*W-1:0] in_data = '0;
    logic           in_last = 1'b0;
    logic [L*W-1:0] out_data;
    logic [L-1:0]   out_lane_valid;
    logic           tile_done;
    logic           busy;

    systolic_skew_feeder #(
        .LANES      (L),
        .DATA_W     (W),
        .FIFO_DEPTH (D)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .out_data       (out_data),
        .out_lane_valid (out_lane_valid),
        .tile_done      (tile_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // model: FIFO queue, log of what was popped at each edge
    logic [L*W:0] q[$];
    bit [L*W-1:0] lg_d [NL];
    bit           lg_v [NL];
    bit           lg_l [NL];
    int           t = 0;
    int           next_ok = 0;
    int           drain_end = 0;
    bit           mid_tile = 1'b0;
    int           n_pushed = 0;
    int           n_lane3 = 0;
    logic [L*W:0] m_e;
    bit           m_pop;
    bit           m_push;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     nm, act, exp, t);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < NL; i++) begin
                lg_v[i] = 1'b0;
                lg_l[i] = 1'b0;
                lg_d[i] = '0;
            end
            next_ok = 0;
            drain_end = 0;
            mid_tile = 1'b0;
        end else begin
            t++;
            m_pop  = (q.size() != 0) && (t >= next_ok);
            m_push = in_valid && (q.size() < D);
            if (m_pop) begin
                m_e = q.pop_front();
                lg_v[t] = 1'b1;
                lg_d[t] = m_e[L*W-1:0];
                lg_l[t] = m_e[L*W];
                if (m_e[L*W]) begin
                    next_ok   = t + L;
                    drain_end = t + L - 1;
                    mid_tile  = 1'b0;
                end else begin
                    mid_tile = 1'b1;
                end
            end
            if (m_push) begin
                q.push_back({in_last, in_data});
                n_pushed++;
            end
        end
    end

    // every-cycle comparison: lane k shows the vector popped k edges ago
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [L*W-1:0] ed;
            logic [L-1:0]   ev;
            logic           etd;
            ed = '0;
            ev = '0;
            etd = 1'b0;
            for (int k = 0; k < L; k++) begin
                int idx;
                idx = t - k;
                if (idx >= 0 && lg_v[idx]) begin
                    ev[k] = 1'b1;
                    ed[k*W +: W] = lg_d[idx][k*W +: W];
                    if (k == L - 1) etd = lg_l[idx];
                end
            end
            chk("cyc_out_data", out_data, ed);
            chk("cyc_lane_valid", out_lane_valid, ev);
            chk("cyc_tile_done", tile_done, etd);
            chk("cyc_in_ready", in_ready, q.size() < D);
            chk("cyc_busy", busy,
                (q.size() != 0) || mid_tile || (t < drain_end));
            if (out_lane_valid[L-1]) n_lane3++;
        end
    end

    // drive a vector at a negedge; returns the edge that accepted it
    task automatic send(input logic [L*W-1:0] d, input logic l,
                        output int acc);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("send_timeout", 1, 0);
        @(negedge clk);
        acc = t;
        in_valid = 1'b0;
    endtask

    task automatic at_t(input int x);
        int g;
        g = 0;
        while (t < x && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 1000) chk("wait_timeout", 1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a, td, anyv, p3, p0;
        logic [3:0] pat [6];
        pat = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;

        // reset state and idle
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_tile_done", tile_done, 0);
        anyv = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_lane_valid != 0 || busy) anyv++;
        end
        chk("idle_quiet", anyv, 0);

        // single-vector tile
        send(32'h13121110, 1'b1, n);
        at_t(n + 1);
        chk("s_l0", out_data[7:0], 8'h10);
        chk("s_v0", out_lane_valid, 4'b0001);
        at_t(n + 2);
        chk("s_l1", out_data[15:8], 8'h11);
        chk("s_v1", out_lane_valid, 4'b0010);
        at_t(n + 3);
        chk("s_l2", out_data[23:16], 8'h12);
        chk("s_busy", busy, 1);
        at_t(n + 4);
        chk("s_l3", out_data[31:24], 8'h13);
        chk("s_v3", out_lane_valid, 4'b1000);
        chk("s_done", tile_done, 1);
        chk("s_busy_end", busy, 0);
        at_t(n + 5);
        chk("s_done_off", tile_done, 0);

        // 3-vector tile back to back, next tile pushed during drain
        at_t(t + 4);
        send(32'h03020100, 1'b0, n);
        fork
            begin
                send(32'h07060504, 1'b0, a);
                send(32'h0b0a0908, 1'b1, a);
                send(32'h23222120, 1'b0, a);
                send(32'h27262524, 1'b1, a);
            end
            begin
                td = 0;
                for (int i = 1; i <= 14; i++) begin
                    at_t(n + i);
                    if (i <= 6) chk("diag", out_lane_valid, pat[i-1]);
                    if (i == 7) begin
                        chk("b1_l0", out_data[7:0], 8'h20);
                        chk("b1_v", out_lane_valid, 4'b0001);
                    end
                    if (tile_done) td++;
                end
                chk("two_done", td, 2);
            end
        join

        // FIFO full during a drain
        at_t(t + 6);
        p3 = n_lane3;
        p0 = n_pushed;
        send(32'h33323130, 1'b1, n);
        send(32'h53525150, 1'b0, a);
        send(32'h57565554, 1'b0, a);
        send(32'h5b5a5958, 1'b0, a);
        send(32'h5f5e5d5c, 1'b0, a);
        chk("full_at", a, n + 4);
        chk("full_ready", in_ready, 0);
        send(32'h63626160, 1'b1, a);
        chk("fifth_acc", a, n + 6);
        at_t(n + 16);
        chk("no_loss", n_lane3 - p3, n_pushed - p0);
        chk("pushed6", n_pushed - p0, 6);

        // bubble: 2-cycle in_valid gap after vector 2
        send(32'h43424140, 1'b0, n);
        fork
            begin
                send(32'h47464544, 1'b0, a);
                @(negedge clk);
                @(negedge clk);
                send(32'h4b4a4948, 1'b0, a);
                send(32'h4f4e4d4c, 1'b1, a);
            end
            begin
                at_t(n + 2);
                chk("g_l0", out_data[7:0], 8'h44);
                at_t(n + 3);
                chk("g_gap0a", {out_lane_valid[0], out_data[7:0]}, 0);
                chk("g_busy", busy, 1);
                at_t(n + 4);
                chk("g_gap0b", {out_lane_valid[0], out_data[7:0]}, 0);
                at_t(n + 6);
                chk("g_gap3a", {out_lane_valid[3], out_data[31:24]}, 0);
                at_t(n + 7);
                chk("g_gap3b", {out_lane_valid[3], out_data[31:24]}, 0);
                at_t(n + 8);
                chk("g_l3", out_data[31:24], 8'h4b);
                chk("g_done_early", tile_done, 0);
                at_t(n + 9);
                chk("g_done", tile_done, 1);
            end
        join

        // mid-tile asynchronous reset
        at_t(t + 6);
        send(32'h73727170, 1'b0, n);
        send(32'h77767574, 1'b0, a);
        send(32'h7b7a7978, 1'b0, a);
        at_t(n + 4);
        chk("r_pre", out_lane_valid, 4'b1110);
        #2 rst_n = 1'b0;
        #1;
        chk("r_valid", out_lane_valid, 0);
        chk("r_data", out_data, 0);
        chk("r_done", tile_done, 0);
        chk("r_busy", busy, 0);
        chk("r_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        anyv = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_lane_valid != 0 || tile_done || busy) anyv++;
        end
        chk("r_stale", anyv, 0);
        send(32'h93929190, 1'b0, n);
        send(32'h97969594, 1'b1, a);
        at_t(n + 1);
        chk("f_l0", out_data[7:0], 8'h90);
        at_t(n + 5);
        chk("f_l3", out_data[31:24], 8'h97);
        chk("f_done", tile_done, 1);
        at_t(t + 6);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
